// File: rtl/memory_arbiter_if.sv
// Bundle between the memory arbiter, its two requesters (0 = CPU, 1 = DMA) and
// a single-port data memory with combinational read.
//   req*/lock*/we*/addr*/wdata* : requester -> arbiter request and access fields
//   gnt*/ack*/rdata*/err*       : arbiter -> requester grant and completion
//   mem_we/mem_addr/mem_data    : arbiter -> memory write port / address
//   mem_q                       : memory -> arbiter combinational read data
// slave  : arbiter side
// master : environment side (requesters plus memory)
interface memory_arbiter_if;
    logic        req0;
    logic        req1;
    logic        lock0;
    logic        lock1;
    logic        we0;
    logic        we1;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic        gnt0;
    logic        gnt1;
    logic        ack0;
    logic        ack1;
    logic        err0;
    logic        err1;
    logic [31:0] rdata0;
    logic [31:0] rdata1;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [31:0] mem_q;

    modport slave (
        input  req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1, mem_q,
        output gnt0, gnt1, ack0, ack1, err0, err1, rdata0, rdata1, mem_we, mem_addr, mem_data
    );

    modport master (
        output req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1, mem_q,
        input  gnt0, gnt1, ack0, ack1, err0, err1, rdata0, rdata1, mem_we, mem_addr, mem_data
    );
endinterface

// File: rtl/memory_arbiter.sv
// Two-requester arbiter in front of a single-port data memory.
// Grants are registered (IDLE/G0/G1); while Gn is held, requester n's address,
// write data and write enable drive the memory combinationally, and one cycle
// later ACKn pulses with registered read data (or ERRn for an out-of-range word).
// Ties resolve round-robin or fixed-priority (requester 0), and a requester may
// hold the grant with LOCKn for up to MAX_BURST contested cycles.
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset
//   bus_io  : requester handshakes and memory port (memory_arbiter_if.slave)
module memory_arbiter #(
    parameter int unsigned DIM        = 1024,
    parameter int unsigned MAX_BURST  = 4,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    memory_arbiter_if.slave  bus_io
);
    localparam int unsigned BurstW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {StIdle, StG0, StG1} state_e;

    state_e              state_q, state_d;
    logic                last_q, last_d;     // id of the last grantee
    logic [BurstW-1:0]   burst_q, burst_d;
    logic                armed_q;            // low for the first edge after reset
    logic                ack0_q, ack0_d, ack1_q, ack1_d;
    logic                err0_q, err0_d, err1_q, err1_d;
    logic [31:0]         rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    logic in_range0, in_range1, burst_open, other_req;

    assign in_range0  = bus_io.addr0 < DIM;
    assign in_range1  = bus_io.addr1 < DIM;
    assign burst_open = burst_q < BurstW'(MAX_BURST);

    // Next grantee, re-evaluated every edge from any state.
    always_comb begin
        state_d = StIdle;
        if (!armed_q) begin
            state_d = StIdle;
        end else if (bus_io.req0 && !bus_io.req1) begin
            state_d = StG0;
        end else if (bus_io.req1 && !bus_io.req0) begin
            state_d = StG1;
        end else if (bus_io.req0 && bus_io.req1) begin
            if (state_q == StG0 && bus_io.lock0 && burst_open) begin
                state_d = StG0;
            end else if (state_q == StG1 && bus_io.lock1 && burst_open) begin
                state_d = StG1;
            end else if (FIXED_PRIO) begin
                state_d = StG0;
            end else begin
                state_d = last_q ? StG0 : StG1;
            end
        end
    end

    // Burst counts consecutive grants to one id while the other side is waiting.
    always_comb begin
        last_d    = last_q;
        burst_d   = BurstW'(1);
        other_req = (state_d == StG0) ? bus_io.req1 : bus_io.req0;
        if (state_d == StG0) last_d = 1'b0;
        if (state_d == StG1) last_d = 1'b1;
        if (state_d != StIdle && state_d == state_q && other_req) begin
            burst_d = (burst_q == BurstW'(MAX_BURST)) ? burst_q : burst_q + BurstW'(1);
        end
    end

    // Memory port follows the current grantee; out-of-range words never reach it.
    always_comb begin
        bus_io.mem_we   = 1'b0;
        bus_io.mem_addr = '0;
        bus_io.mem_data = '0;
        unique case (state_q)
            StG0: begin
                bus_io.mem_we   = bus_io.we0 & in_range0;
                bus_io.mem_addr = in_range0 ? bus_io.addr0 : '0;
                bus_io.mem_data = bus_io.wdata0;
            end
            StG1: begin
                bus_io.mem_we   = bus_io.we1 & in_range1;
                bus_io.mem_addr = in_range1 ? bus_io.addr1 : '0;
                bus_io.mem_data = bus_io.wdata1;
            end
            default: begin
                bus_io.mem_we   = 1'b0;
            end
        endcase
    end

    // Completion of the access made in the current grant cycle; writes keep RDATA.
    always_comb begin
        ack0_d   = (state_q == StG0);
        ack1_d   = (state_q == StG1);
        err0_d   = ack0_d & ~in_range0;
        err1_d   = ack1_d & ~in_range1;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        if (ack0_d) begin
            if (!in_range0)         rdata0_d = '0;
            else if (!bus_io.we0)   rdata0_d = bus_io.mem_q;
        end
        if (ack1_d) begin
            if (!in_range1)         rdata1_d = '0;
            else if (!bus_io.we1)   rdata1_d = bus_io.mem_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            last_q   <= 1'b1;
            burst_q  <= '0;
            armed_q  <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            burst_q  <= burst_d;
            armed_q  <= 1'b1;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            err0_q   <= err0_d;
            err1_q   <= err1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign bus_io.gnt0   = (state_q == StG0);
    assign bus_io.gnt1   = (state_q == StG1);
    assign bus_io.ack0   = ack0_q;
    assign bus_io.ack1   = ack1_q;
    assign bus_io.err0   = err0_q;
    assign bus_io.err1   = err1_q;
    assign bus_io.rdata0 = rdata0_q;
    assign bus_io.rdata1 = rdata1_q;
endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: a round-robin instance and a fixed-priority instance
// see identical requester stimulus, each with its own memory. A table of
// hand-derived vectors, hand-written reset/priority sequences and a random phase
// are all checked against a reference model of the arbitration rules.
module tb_memory_arbiter;
    localparam int unsigned DIM   = 1024;
    localparam int unsigned MAXB  = 4;

    logic clk;
    logic rst_n;
    logic preload;

    logic        req0, req1, lock0, lock1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;

    logic [31:0] env_mem0 [DIM];
    logic [31:0] env_mem1 [DIM];

    int vectors;
    int miscompares;

    memory_arbiter_if bus_rr ();
    memory_arbiter_if bus_fp ();

    assign bus_rr.req0 = req0;    assign bus_fp.req0 = req0;
    assign bus_rr.req1 = req1;    assign bus_fp.req1 = req1;
    assign bus_rr.lock0 = lock0;  assign bus_fp.lock0 = lock0;
    assign bus_rr.lock1 = lock1;  assign bus_fp.lock1 = lock1;
    assign bus_rr.we0 = we0;      assign bus_fp.we0 = we0;
    assign bus_rr.we1 = we1;      assign bus_fp.we1 = we1;
    assign bus_rr.addr0 = addr0;  assign bus_fp.addr0 = addr0;
    assign bus_rr.addr1 = addr1;  assign bus_fp.addr1 = addr1;
    assign bus_rr.wdata0 = wdata0; assign bus_fp.wdata0 = wdata0;
    assign bus_rr.wdata1 = wdata1; assign bus_fp.wdata1 = wdata1;
    assign bus_rr.mem_q = env_mem0[bus_rr.mem_addr[9:0]];
    assign bus_fp.mem_q = env_mem1[bus_fp.mem_addr[9:0]];

    memory_arbiter #(.DIM(DIM), .MAX_BURST(MAXB), .FIXED_PRIO(1'b0)) dut_rr (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus_io (bus_rr)
    );

    memory_arbiter #(.DIM(DIM), .MAX_BURST(MAXB), .FIXED_PRIO(1'b1)) dut_fp (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus_io (bus_fp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < int'(DIM); i++) begin
                env_mem0[i] <= 32'hCAFE_0000 | 32'(i);
                env_mem1[i] <= 32'hCAFE_0000 | 32'(i);
            end
        end else begin
            if (bus_rr.mem_we) env_mem0[bus_rr.mem_addr[9:0]] <= bus_rr.mem_data;
            if (bus_fp.mem_we) env_mem1[bus_fp.mem_addr[9:0]] <= bus_fp.mem_data;
        end
    end

    // ---------------- reference model (lane 0 = round-robin, 1 = fixed) ----------
    int          m_owner [2];   // -1 idle, else grantee id
    int          m_last  [2];
    int          m_run   [2];   // contested consecutive grants to the owner
    bit          m_armed [2];
    bit          m_ack   [2][2];
    bit          m_err   [2][2];
    logic [31:0] m_rdata [2][2];
    logic [31:0] m_mem   [2][DIM];

    task automatic model_reset();
        for (int ln = 0; ln < 2; ln++) begin
            m_owner[ln] = -1;
            m_last[ln]  = 1;
            m_run[ln]   = 0;
            m_armed[ln] = 1'b0;
            for (int n = 0; n < 2; n++) begin
                m_ack[ln][n]   = 1'b0;
                m_err[ln][n]   = 1'b0;
                m_rdata[ln][n] = '0;
            end
        end
    endtask

    // Called just after a rising edge, with the inputs that were present before it.
    task automatic model_step();
        bit          r [2];
        bit          l [2];
        bit          w [2];
        logic [31:0] a [2];
        logic [31:0] d [2];
        int          o, nxt;
        if (!rst_n) return;
        r[0] = req0;  r[1] = req1;  l[0] = lock0;  l[1] = lock1;
        w[0] = we0;   w[1] = we1;   a[0] = addr0;  a[1] = addr1;
        d[0] = wdata0; d[1] = wdata1;
        for (int ln = 0; ln < 2; ln++) begin
            o = m_owner[ln];
            m_ack[ln][0] = 1'b0; m_ack[ln][1] = 1'b0;
            m_err[ln][0] = 1'b0; m_err[ln][1] = 1'b0;
            if (o >= 0) begin
                m_ack[ln][o] = 1'b1;
                if (a[o] >= DIM) begin
                    m_err[ln][o]   = 1'b1;
                    m_rdata[ln][o] = '0;
                end else if (w[o]) begin
                    m_mem[ln][a[o][9:0]] = d[o];
                end else begin
                    m_rdata[ln][o] = m_mem[ln][a[o][9:0]];
                end
            end
            if (!m_armed[ln]) begin
                m_armed[ln] = 1'b1;
                nxt = -1;
            end else if (!r[0] && !r[1]) begin
                nxt = -1;
            end else if (r[0] != r[1]) begin
                nxt = r[0] ? 0 : 1;
            end else if (o >= 0 && l[o] && m_run[ln] < int'(MAXB)) begin
                nxt = o;
            end else begin
                nxt = (ln == 1) ? 0 : 1 - m_last[ln];
            end
            if (nxt >= 0 && nxt == o && r[1 - nxt])
                m_run[ln] = (m_run[ln] < int'(MAXB)) ? m_run[ln] + 1 : m_run[ln];
            else
                m_run[ln] = 1;
            if (nxt >= 0) m_last[ln] = nxt;
            m_owner[ln] = nxt;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_lane(input int ln, input logic [5:0] flags, input logic [31:0] rd0,
                              input logic [31:0] rd1, input logic mwe,
                              input logic [31:0] maddr, input logic [31:0] mdata);
        logic [5:0]  ef;
        logic        ewe;
        logic [31:0] ea, ed, aa;
        int          o;
        string       tag;
        o   = m_owner[ln];
        tag = (ln == 0) ? "rr" : "fp";
        ef  = {o == 0, o == 1, m_ack[ln][0], m_ack[ln][1], m_err[ln][0], m_err[ln][1]};
        ewe = 1'b0; ea = '0; ed = '0;
        if (o >= 0) begin
            aa  = (o == 0) ? addr0 : addr1;
            ewe = ((o == 0) ? we0 : we1) && (aa < DIM);
            ea  = (aa < DIM) ? aa : '0;
            ed  = (o == 0) ? wdata0 : wdata1;
        end
        chk({tag, " gnt/ack/err"}, {26'd0, flags}, {26'd0, ef});
        chk({tag, " rdata0"}, rd0, m_rdata[ln][0]);
        chk({tag, " rdata1"}, rd1, m_rdata[ln][1]);
        chk({tag, " mem_we"}, {31'd0, mwe}, {31'd0, ewe});
        chk({tag, " mem_addr"}, maddr, ea);
        chk({tag, " mem_data"}, mdata, ed);
    endtask

    task automatic model_check();
        check_lane(0, {bus_rr.gnt0, bus_rr.gnt1, bus_rr.ack0, bus_rr.ack1, bus_rr.err0,
                   bus_rr.err1}, bus_rr.rdata0, bus_rr.rdata1, bus_rr.mem_we,
                   bus_rr.mem_addr, bus_rr.mem_data);
        check_lane(1, {bus_fp.gnt0, bus_fp.gnt1, bus_fp.ack0, bus_fp.ack1, bus_fp.err0,
                   bus_fp.err1}, bus_fp.rdata0, bus_fp.rdata1, bus_fp.mem_we,
                   bus_fp.mem_addr, bus_fp.mem_data);
    endtask

    // Inputs are applied at a falling edge; this advances one rising edge and checks.
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        model_check();
    endtask

    task automatic drive(input bit r0, input bit r1, input bit l0, input bit l1,
                         input bit w0, input bit w1, input logic [31:0] a0,
                         input logic [31:0] a1, input logic [31:0] d0, input logic [31:0] d1);
        req0 = r0; req1 = r1; lock0 = l0; lock1 = l1; we0 = w0; we1 = w1;
        addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
    endtask

    // ---------------- hand-derived vectors for the round-robin instance ----------
    typedef struct {
        bit          r0, r1, l0, l1, w0, w1;
        logic [31:0] a0, a1, d0, d1;
        logic [1:0]  gnt;   // {gnt0, gnt1} after the edge
        logic [1:0]  ack;   // {ack0, ack1}
        logic [1:0]  err;   // {err0, err1}
        logic [31:0] rd0, rd1;
        bit          mwe;
    } vec_t;

    function automatic vec_t mk(input bit r0, input bit r1, input bit l1, input bit w1,
                                input logic [31:0] a0, input logic [31:0] a1,
                                input logic [31:0] d1, input logic [1:0] gnt,
                                input logic [1:0] ack, input logic [1:0] err,
                                input logic [31:0] rd0, input logic [31:0] rd1,
                                input bit mwe);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.l0 = 1'b0; v.l1 = l1; v.w0 = 1'b0; v.w1 = w1;
        v.a0 = a0; v.a1 = a1; v.d0 = 32'h0; v.d1 = d1;
        v.gnt = gnt; v.ack = ack; v.err = err; v.rd0 = rd0; v.rd1 = rd1; v.mwe = mwe;
        return v;
    endfunction

    vec_t tbl [17];

    initial begin
        vectors     = 0;
        miscompares = 0;
        //          r0 r1 l1 w1 a0  a1    d1            gnt    ack    err    rd0           rd1           mwe
        tbl[0]  = mk(1, 0, 0, 0, 5,  0,    0,            2'b00, 2'b00, 2'b00, 32'h0,        32'h0,        0);
        tbl[1]  = mk(1, 0, 0, 0, 5,  0,    0,            2'b10, 2'b00, 2'b00, 32'h0,        32'h0,        0);
        tbl[2]  = mk(0, 0, 0, 0, 5,  0,    0,            2'b00, 2'b10, 2'b00, 32'hCAFE0005, 32'h0,        0);
        tbl[3]  = mk(1, 1, 0, 0, 6,  7,    0,            2'b01, 2'b00, 2'b00, 32'hCAFE0005, 32'h0,        0);
        tbl[4]  = mk(1, 1, 0, 0, 6,  7,    0,            2'b10, 2'b01, 2'b00, 32'hCAFE0005, 32'hCAFE0007, 0);
        tbl[5]  = mk(1, 1, 0, 0, 6,  7,    0,            2'b01, 2'b10, 2'b00, 32'hCAFE0006, 32'hCAFE0007, 0);
        tbl[6]  = mk(0, 1, 0, 1, 6,  1024, 32'hDEADBEEF, 2'b01, 2'b01, 2'b01, 32'hCAFE0006, 32'h0,        0);
        tbl[7]  = mk(0, 1, 0, 1, 6,  9,    32'h12345678, 2'b01, 2'b01, 2'b00, 32'hCAFE0006, 32'h0,        1);
        tbl[8]  = mk(1, 0, 0, 1, 9,  9,    32'h12345678, 2'b10, 2'b01, 2'b00, 32'hCAFE0006, 32'h0,        0);
        tbl[9]  = mk(0, 0, 0, 0, 9,  0,    0,            2'b00, 2'b10, 2'b00, 32'h12345678, 32'h0,        0);
        tbl[10] = mk(0, 0, 0, 0, 0,  0,    0,            2'b00, 2'b00, 2'b00, 32'h12345678, 32'h0,        0);
        tbl[11] = mk(1, 1, 1, 0, 2,  3,    0,            2'b01, 2'b00, 2'b00, 32'h12345678, 32'h0,        0);
        tbl[12] = mk(1, 1, 1, 0, 2,  3,    0,            2'b01, 2'b01, 2'b00, 32'h12345678, 32'hCAFE0003, 0);
        tbl[13] = mk(1, 1, 1, 0, 2,  3,    0,            2'b01, 2'b01, 2'b00, 32'h12345678, 32'hCAFE0003, 0);
        tbl[14] = mk(1, 1, 1, 0, 2,  3,    0,            2'b01, 2'b01, 2'b00, 32'h12345678, 32'hCAFE0003, 0);
        tbl[15] = mk(1, 1, 1, 0, 2,  3,    0,            2'b10, 2'b01, 2'b00, 32'h12345678, 32'hCAFE0003, 0);
        tbl[16] = mk(0, 0, 0, 0, 2,  3,    0,            2'b00, 2'b10, 2'b00, 32'hCAFE0002, 32'hCAFE0003, 0);

        for (int ln = 0; ln < 2; ln++)
            for (int i = 0; i < int'(DIM); i++) m_mem[ln][i] = 32'hCAFE_0000 | 32'(i);
        model_reset();
        rst_n   = 1'b0;
        preload = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        preload = 1'b0;
        chk("reset gnt0", {31'd0, bus_rr.gnt0}, 32'd0);
        chk("reset ack0", {31'd0, bus_rr.ack0}, 32'd0);
        model_check();
        rst_n = 1'b1;

        // Table vectors, straight out of reset (first edge only arms the arbiter).
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].r0, tbl[i].r1, tbl[i].l0, tbl[i].l1, tbl[i].w0, tbl[i].w1,
                  tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1);
            step();
            chk($sformatf("vec%0d gnt", i), {30'd0, bus_rr.gnt0, bus_rr.gnt1}, {30'd0, tbl[i].gnt});
            chk($sformatf("vec%0d ack", i), {30'd0, bus_rr.ack0, bus_rr.ack1}, {30'd0, tbl[i].ack});
            chk($sformatf("vec%0d err", i), {30'd0, bus_rr.err0, bus_rr.err1}, {30'd0, tbl[i].err});
            chk($sformatf("vec%0d rdata0", i), bus_rr.rdata0, tbl[i].rd0);
            chk($sformatf("vec%0d rdata1", i), bus_rr.rdata1, tbl[i].rd1);
            chk($sformatf("vec%0d mem_we", i), {31'd0, bus_rr.mem_we}, {31'd0, tbl[i].mwe});
        end
        chk("oob write left word 0", env_mem0[0], 32'hCAFE0000);

        // Reset asserted in the middle of a G0 write cycle.
        drive(1, 0, 0, 0, 1, 0, 20, 0, 32'hBAD0BAD0, 0);
        step();
        chk("pre-reset gnt0", {31'd0, bus_rr.gnt0}, 32'd1);
        chk("pre-reset mem_we", {31'd0, bus_rr.mem_we}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset gnt0", {31'd0, bus_rr.gnt0}, 32'd0);
        chk("async reset mem_we", {31'd0, bus_rr.mem_we}, 32'd0);
        model_reset();
        model_check();
        @(posedge clk);
        model_step();
        @(negedge clk);
        rst_n = 1'b1;
        chk("aborted write word 20", env_mem0[20], 32'hCAFE0014);
        drive(1, 1, 0, 0, 0, 0, 30, 31, 0, 0);
        step();
        chk("first edge after reset no grant", {30'd0, bus_rr.gnt0, bus_rr.gnt1}, 32'd0);
        step();
        chk("post-reset tie grants 0", {30'd0, bus_rr.gnt0, bus_rr.gnt1}, 32'd2);
        step();
        chk("post-reset tie then 1", {30'd0, bus_rr.gnt0, bus_rr.gnt1}, 32'd1);

        // Fixed priority: requester 0 keeps the memory under a sustained tie.
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        drive(1, 1, 0, 0, 0, 0, 1, 2, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("fixed tie %0d", i), {30'd0, bus_fp.gnt0, bus_fp.gnt1}, 32'd2);
        end

        // Random phase against the model.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 9) == 0) ? 32'($urandom_range(1020, 1100)) :
                                                32'($urandom_range(0, 63)),
                  ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3)) :
                                                32'($urandom_range(0, 63)),
                  $urandom, $urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
